bht_access_ctrl: RTL

- Controller for the branch history table (BHT) that backs branch prediction.
- Shares one single-port table RAM between fetch-side lookups and RS-side training updates.
- Buffers training requests in a small queue and performs training as read-modify-write on 2-bit saturating counters.
- Initialises the whole table after reset. Sits between Fetcher/RS and the BHT RAM.

---
 rtl/bht_access_ctrl_pkg.sv | 33 +++
 rtl/bht_access_ctrl_if.sv | 37 +++
 rtl/bht_train_queue.sv | 62 ++++++
 rtl/bht_access_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bht_access_ctrl_pkg.sv
// rtl/bht_access_ctrl_pkg.sv - shared encodings, FSM states and counter update for the BHT controller
`ifndef BHT_ACCESS_CTRL_DEFS
`define BHT_ACCESS_CTRL_DEFS
`define Data_Bus 32
`define True     1'b1
`define False    1'b0
`endif

package bht_access_ctrl_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_WR
    } state_e;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bht_access_ctrl_if.sv
// rtl/bht_access_ctrl_if.sv - fetch, RS and table RAM signals of the BHT controller
interface bht_access_ctrl_if #(
    parameter int IDX_W    = 8,
    parameter int TQ_DEPTH = 4
);
    localparam int CNT_W = $clog2(TQ_DEPTH) + 1;

    logic                 rdy;
    logic                 lookup_valid;
    logic [`Data_Bus-1:0] lookup_pc;
    logic                 lookup_ready;
    logic                 pred_valid;
    logic                 pred_taken;
    logic                 train_valid;
    logic [`Data_Bus-1:0] train_pc;
    logic                 train_taken;
    logic                 train_ready;
    logic                 ram_en;
    logic                 ram_we;
    logic [IDX_W-1:0]     ram_addr;
    logic [1:0]           ram_wdata;
    logic [1:0]           ram_rdata;
    logic                 init_done;
    logic [CNT_W-1:0]     tq_count;

    modport slave (
        input  rdy, lookup_valid, lookup_pc, train_valid, train_pc, train_taken, ram_rdata,
        output lookup_ready, pred_valid, pred_taken, train_ready,
               ram_en, ram_we, ram_addr, ram_wdata, init_done, tq_count
    );

    modport master (
        output rdy, lookup_valid, lookup_pc, train_valid, train_pc, train_taken, ram_rdata,
        input  lookup_ready, pred_valid, pred_taken, train_ready,
               ram_en, ram_we, ram_addr, ram_wdata, init_done, tq_count
    );
endinterface

// File: rtl/bht_train_queue.sv
// rtl/bht_train_queue.sv - power-of-two FIFO holding pending {index, taken} training requests
module bht_train_queue #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/bht_access_ctrl.sv
// rtl/bht_access_ctrl.sv - shares one BHT RAM port between fetch lookups and queued RMW training
module bht_access_ctrl
    import bht_access_ctrl_pkg::*;
#(
    parameter int         IDX_W    = 8,
    parameter int         TQ_DEPTH = 4,
    parameter logic [1:0] INIT_CNT = CNT_WNT
) (
    input  logic             clk,
    input  logic             rst,
    bht_access_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TQ_DEPTH) + 1;
    localparam int Q_W   = IDX_W + 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             init_done_q, init_done_d;
    logic             pred_valid_q, pred_valid_d;
    logic [1:0]       cnt_q, cnt_d;

    logic             q_push, q_pop, q_full, q_empty;
    logic [Q_W-1:0]   q_head;
    logic [CNT_W-1:0] q_count;

    logic [IDX_W-1:0] lookup_idx, train_idx, head_idx;
    logic             head_taken, in_rw, lookup_acc, train_gnt;
    logic             ram_en, ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [1:0]       ram_wdata;
    logic             unused_pc_bits;

    assign lookup_idx     = bus.lookup_pc[IDX_W+1:2];
    assign train_idx      = bus.train_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.lookup_pc[`Data_Bus-1:IDX_W+2], bus.lookup_pc[1:0],
                              bus.train_pc[`Data_Bus-1:IDX_W+2], bus.train_pc[1:0]};
    assign head_idx       = q_head[Q_W-1:1];
    assign head_taken     = q_head[0];

    // A full queue blocks lookups while training needs the port, so training cannot starve.
    assign in_rw            = (state_q == ST_RD) || (state_q == ST_WR);
    assign bus.lookup_ready = !rst && bus.rdy && init_done_q && !(q_full && in_rw);
    assign lookup_acc       = bus.lookup_valid && bus.lookup_ready;
    assign bus.train_ready  = !rst && bus.rdy && init_done_q && !q_full;
    assign train_gnt        = !rst && bus.rdy && !lookup_acc;
    assign q_push           = bus.train_valid && bus.train_ready;
    assign q_pop            = (state_q == ST_WR) && train_gnt;

    bht_train_queue #(.W(Q_W), .DEPTH(TQ_DEPTH)) u_train_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({train_idx, bus.train_taken}),
        .pop       (q_pop),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        init_done_d  = init_done_q;
        cnt_d        = cnt_q;
        pred_valid_d = lookup_acc;
        ram_en       = lookup_acc;
        ram_we       = 1'b0;
        ram_addr     = lookup_acc ? lookup_idx : '0;
        ram_wdata    = '0;
        if (!rst && bus.rdy) begin
            case (state_q)
                ST_INIT: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = sweep_q;
                    ram_wdata = INIT_CNT;
                    sweep_d   = sweep_q + IDX_W'(1);
                    if (&sweep_q) begin
                        state_d     = ST_IDLE;
                        init_done_d = `True;
                    end
                end
                ST_IDLE: if (!q_empty) state_d = ST_RD;
                ST_RD: if (train_gnt) begin
                    ram_en   = 1'b1;
                    ram_addr = head_idx;
                    state_d  = ST_CALC;
                end
                // Read data from RD is on ram_rdata now; the updated value is held in cnt_q.
                ST_CALC: begin
                    cnt_d   = sat_update(bus.ram_rdata, head_taken);
                    state_d = ST_WR;
                end
                ST_WR: if (train_gnt) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = head_idx;
                    ram_wdata = cnt_q;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            init_done_q  <= `False;
            pred_valid_q <= `False;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            init_done_q  <= init_done_d;
            pred_valid_q <= pred_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.ram_en     = ram_en;
    assign bus.ram_we     = ram_we;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_wdata  = ram_wdata;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_valid_q && bus.ram_rdata[1];
    assign bus.init_done  = init_done_q;
    assign bus.tq_count   = q_count;

endmodule
